// File: rtl/hd44780_responder_pkg.sv
// Shared constants, opcode decode and address-counter helpers for the HD44780 responder.
package hd44780_responder_pkg;

  localparam int         DDRAM_SIZE = 80;
  localparam int         LINE_LEN   = 40;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;
  localparam logic [7:0] SPACE      = 8'h20;

  typedef enum logic [3:0] {
    OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPLAY,
    OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
  } op_e;

  // Instruction class is chosen by the highest set bit of the opcode.
  function automatic op_e decode_op(input logic [7:0] d);
    op_e op;
    casez (d)
      8'b1???????: op = OP_DDRAM;
      8'b01??????: op = OP_CGRAM;
      8'b001?????: op = OP_FUNC;
      8'b0001????: op = OP_SHIFT;
      8'b00001???: op = OP_DISPLAY;
      8'b000001??: op = OP_ENTRY;
      8'b0000001?: op = OP_HOME;
      8'b00000001: op = OP_CLEAR;
      default:     op = OP_NOP;
    endcase
    return op;
  endfunction

  function automatic logic ac_legal(input logic [6:0] a);
    return (a <= LINE1_LAST) || ((a >= LINE2_BASE) && (a <= LINE2_LAST));
  endfunction

  // Step the address counter across the two 40-char line windows.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (a == LINE1_LAST)      n = LINE2_BASE;
      else if (a == LINE2_LAST) n = 7'h00;
      else                      n = a + 7'd1;
    end else begin
      if (a == 7'h00)           n = LINE2_LAST;
      else if (a == LINE2_BASE) n = LINE1_LAST;
      else                      n = a - 7'd1;
    end
    return n;
  endfunction

  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    return a[6] ? (7'(LINE_LEN) + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
  endfunction

endpackage

// File: rtl/hd44780_responder_lcd_bus_sync.sv
// Two-flop synchronisers for the asynchronous bus pins plus E edge pulses.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  input  logic [7:0] db_in,
  output logic       rs_s,
  output logic       rw_s,
  output logic       e_s,
  output logic [7:0] db_s,
  output logic       e_rise,
  output logic       e_fall
);

  logic [10:0] meta_q;
  logic [10:0] sync_q;
  logic        e_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      e_d    <= 1'b0;
    end else begin
      meta_q <= {rs, rw, e, db_in};
      sync_q <= meta_q;
      e_d    <= sync_q[8];
    end
  end

  assign {rs_s, rw_s, e_s, db_s} = sync_q;
  assign e_rise = e_s & ~e_d;
  assign e_fall = ~e_s & e_d;

endmodule

// File: rtl/hd44780_responder.sv
// HD44780-style bus target: executes instructions/data writes, answers status and data reads,
// and exposes the 80-char DDRAM through a read-only scan port.
module hd44780_responder
  import hd44780_responder_pkg::*;
#(
  parameter int CMD_CYCLES   = 120,
  parameter int CLEAR_CYCLES = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [6:0] scan_addr,
  output logic [7:0] scan_data,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] cursor_addr,
  output logic       busy,
  output logic       protocol_err
);

  localparam int            CW         = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);

  logic       rs_s, rw_s, e_s, e_rise, e_fall;
  logic [7:0] db_s;

  lcd_bus_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rs     (rs),
    .rw     (rw),
    .e      (e),
    .db_in  (db_in),
    .rs_s   (rs_s),
    .rw_s   (rw_s),
    .e_s    (e_s),
    .db_s   (db_s),
    .e_rise (e_rise),
    .e_fall (e_fall)
  );

  logic [6:0]    ac;
  logic          i_d;
  logic [CW-1:0] busy_cnt;
  logic          sweep_active;
  logic [6:0]    sweep_idx;
  logic          rd_pending;
  logic          rd_step;

  logic       accept, reject, data_wr;
  logic       a_we;
  logic [6:0] a_addr;
  logic [7:0] a_wdata;
  logic [7:0] ra_q;
  op_e        op;

  assign busy        = (busy_cnt != '0);
  assign cursor_addr = ac;
  assign op          = decode_op(db_s);

  // The pre-decrement counter decides acceptance, so expiry and a write in one cycle rejects it.
  assign accept  = e_fall & ~rw_s & ~busy;
  assign reject  = e_fall & ~rw_s & busy;
  assign data_wr = accept & rs_s;

  assign a_we    = sweep_active | data_wr;
  assign a_addr  = sweep_active ? sweep_idx : ddram_idx(ac);
  assign a_wdata = sweep_active ? SPACE : db_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac           <= 7'h00;
      i_d          <= 1'b1;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      busy_cnt     <= CLEAR_LOAD;
      protocol_err <= 1'b0;
      sweep_active <= 1'b1;
      sweep_idx    <= 7'd0;
      db_out       <= 8'h00;
      db_oe        <= 1'b0;
      rd_pending   <= 1'b0;
      rd_step      <= 1'b0;
    end else begin
      db_oe <= e_s & rw_s;

      if (busy) busy_cnt <= busy_cnt - 1'b1;

      if (sweep_active) begin
        if (sweep_idx == 7'(DDRAM_SIZE - 1)) sweep_active <= 1'b0;
        sweep_idx <= sweep_idx + 7'd1;
      end

      if (rd_pending) begin
        db_out     <= ra_q;
        rd_pending <= 1'b0;
      end

      if (e_rise && rw_s) begin
        rd_step <= 1'b0;
        if (!rs_s) begin
          db_out <= {busy, ac};
        end else if (busy) begin
          db_out <= 8'hFF;
        end else begin
          rd_pending <= 1'b1;
          rd_step    <= 1'b1;
        end
      end

      if (e_fall) begin
        rd_step <= 1'b0;
        if (rw_s && rd_step) ac <= ac_step(ac, i_d);
      end

      if (reject) protocol_err <= 1'b1;

      if (accept) begin
        if (rs_s) begin
          ac       <= ac_step(ac, i_d);
          busy_cnt <= CMD_LOAD;
        end else begin
          if (op != OP_NOP) busy_cnt <= CMD_LOAD;
          unique case (op)
            OP_DDRAM:   ac <= ac_legal(db_s[6:0]) ? db_s[6:0] : 7'h00;
            OP_SHIFT:   if (!db_s[3]) ac <= ac_step(ac, db_s[2]);
            OP_DISPLAY: {display_on, cursor_on, blink_on} <= db_s[2:0];
            OP_ENTRY:   i_d <= db_s[1];
            OP_HOME: begin
              ac       <= 7'h00;
              busy_cnt <= CLEAR_LOAD;
            end
            OP_CLEAR: begin
              ac           <= 7'h00;
              i_d          <= 1'b1;
              busy_cnt     <= CLEAR_LOAD;
              sweep_active <= 1'b1;
              sweep_idx    <= 7'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Port A serves sweep/bus writes and bus reads; port B is the scan read.
  logic [7:0] ddram [DDRAM_SIZE];
  logic [6:0] scan_idx;
  logic [7:0] scan_q;
  logic       scan_ok_q;

  assign scan_idx = (scan_addr < 7'(DDRAM_SIZE)) ? scan_addr : 7'd0;

  // NOTE: the array has no reset so it maps onto block RAM; the post-reset sweep initialises it.
  always_ff @(posedge clk) begin
    if (a_we) ddram[a_addr] <= a_wdata;
    else      ra_q          <= ddram[a_addr];
  end

  always_ff @(posedge clk) begin
    scan_q <= ddram[scan_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) scan_ok_q <= 1'b0;
    else       scan_ok_q <= (scan_addr < 7'(DDRAM_SIZE));
  end

  assign scan_data = scan_ok_q ? scan_q : 8'h00;

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder: bus transactions with hand-computed expectations.
module tb_hd44780_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rs, rw, e;
  logic [7:0] db_in;
  logic [7:0] db_out;
  logic       db_oe;
  logic [6:0] scan_addr;
  logic [7:0] scan_data;
  logic       display_on, cursor_on, blink_on;
  logic [6:0] cursor_addr;
  logic       busy, protocol_err;

  int tests  = 0;
  int failed = 0;
  int unsigned cyc = 0;

  hd44780_responder #(.CMD_CYCLES(120), .CLEAR_CYCLES(4800)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs           (rs),
    .rw           (rw),
    .e            (e),
    .db_in        (db_in),
    .db_out       (db_out),
    .db_oe        (db_oe),
    .scan_addr    (scan_addr),
    .scan_data    (scan_data),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .cursor_addr  (cursor_addr),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic rs_v, input logic [7:0] d);
    @(negedge clk);
    rs = rs_v; rw = 1'b0; db_in = d;
    repeat (2) @(negedge clk);
    e = 1'b1;
    repeat (4) @(negedge clk);
    e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_read(input logic rs_v, output logic [7:0] d, output logic oe);
    @(negedge clk);
    rs = rs_v; rw = 1'b1;
    repeat (2) @(negedge clk);
    e = 1'b1;
    repeat (5) @(negedge clk);
    d  = db_out;
    oe = db_oe;
    e  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic scan_read(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    scan_addr = a;
    @(negedge clk);
    d = scan_data;
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    logic       oe;

    reset = 1'b1; rs = 1'b0; rw = 1'b0; e = 1'b0; db_in = 8'h00; scan_addr = 7'd0;
    repeat (5) @(negedge clk);
    check("rst_db_out",  32'(db_out), 32'h00);
    check("rst_db_oe",   32'(db_oe), 32'd0);
    check("rst_disp",    32'({display_on, cursor_on, blink_on}), 32'd0);
    check("rst_ac",      32'(cursor_addr), 32'h00);
    check("rst_busy",    32'(busy), 32'd1);
    check("rst_perr",    32'(protocol_err), 32'd0);

    // 1: power-up clear sweep and busy window
    reset = 1'b0;
    repeat (50) @(negedge clk);
    bus_read(1'b0, rd, oe);
    check("status_busy", 32'(rd), 32'h80);
    check("status_oe",   32'(oe), 32'd1);
    wait_cyc(4799);
    check("busy_4799",   32'(busy), 32'd1);
    wait_cyc(4800);
    check("busy_4800",   32'(busy), 32'd0);
    bus_read(1'b0, rd, oe);
    check("status_idle", 32'(rd), 32'h00);
    for (int i = 0; i < 80; i++) begin
      scan_read(7'(i), rd);
      check($sformatf("sweep_%0d", i), 32'(rd), 32'h20);
    end
    scan_read(7'd80, rd);
    check("scan_80", 32'(rd), 32'h00);
    scan_read(7'd127, rd);
    check("scan_127", 32'(rd), 32'h00);

    // 2: line-1 end wraps into line 2
    bus_write(1'b0, 8'hA7); wait_idle();
    bus_write(1'b1, 8'h41); wait_idle();
    bus_write(1'b1, 8'h42); wait_idle();
    scan_read(7'd39, rd); check("scan_39_A", 32'(rd), 32'h41);
    scan_read(7'd40, rd); check("scan_40_B", 32'(rd), 32'h42);
    bus_read(1'b0, rd, oe);
    check("status_41", 32'(rd), 32'h41);

    // 3: write while busy is rejected
    bus_write(1'b1, 8'h5A);
    bus_write(1'b1, 8'h51);
    check("perr_set",   32'(protocol_err), 32'd1);
    check("ac_held",    32'(cursor_addr), 32'h42);
    wait_idle();
    scan_read(7'd41, rd); check("scan_41_Z", 32'(rd), 32'h5A);
    scan_read(7'd42, rd); check("scan_42_untouched", 32'(rd), 32'h20);

    // data read while busy returns 0xFF and holds AC
    bus_write(1'b0, 8'h85);
    bus_read(1'b1, rd, oe);
    check("busy_read_ff", 32'(rd), 32'hFF);
    check("busy_read_ac", 32'(cursor_addr), 32'h05);
    wait_idle();

    // illegal DDRAM addresses and cursor shifts
    bus_write(1'b0, 8'hA8); wait_idle(); check("ac_illegal_28", 32'(cursor_addr), 32'h00);
    bus_write(1'b0, 8'hC5); wait_idle(); check("ac_45",         32'(cursor_addr), 32'h45);
    bus_write(1'b0, 8'hFF); wait_idle(); check("ac_illegal_7f", 32'(cursor_addr), 32'h00);
    bus_write(1'b0, 8'h10); wait_idle(); check("shift_dec_wrap", 32'(cursor_addr), 32'h67);
    bus_write(1'b0, 8'h14); wait_idle(); check("shift_inc_wrap", 32'(cursor_addr), 32'h00);
    bus_write(1'b0, 8'hC0); wait_idle();
    bus_write(1'b0, 8'h18); wait_idle(); check("display_shift_ignored", 32'(cursor_addr), 32'h40);

    // 4: decrement mode wraps 0x00 -> 0x67
    bus_write(1'b0, 8'h04); wait_idle();
    bus_write(1'b0, 8'h80); wait_idle();
    bus_write(1'b1, 8'h58); wait_idle();
    scan_read(7'd0, rd); check("scan_0_X", 32'(rd), 32'h58);
    check("ac_dec_wrap", 32'(cursor_addr), 32'h67);

    // 5: display control and data read
    bus_write(1'b0, 8'h0C); wait_idle();
    check("dcb", 32'({display_on, cursor_on, blink_on}), 32'b100);
    bus_write(1'b0, 8'h06); wait_idle();
    bus_write(1'b0, 8'hC0); wait_idle();
    bus_read(1'b1, rd, oe);
    check("data_read_40", 32'(rd), 32'h42);
    check("data_read_oe", 32'(oe), 32'd1);
    check("data_read_ac", 32'(cursor_addr), 32'h41);
    check("oe_after",     32'(db_oe), 32'd0);

    // no-op sets no busy; protocol_err stays sticky
    bus_write(1'b0, 8'h00);
    check("nop_no_busy", 32'(busy), 32'd0);
    check("perr_sticky", 32'(protocol_err), 32'd1);

    // return home: long busy, AC cleared
    bus_write(1'b0, 8'h02);
    check("home_busy", 32'(busy), 32'd1);
    check("home_ac",   32'(cursor_addr), 32'h00);
    wait_idle();

    // 6: reset mid clear sweep and mid read
    bus_write(1'b0, 8'hDE); wait_idle();
    bus_write(1'b1, 8'h4D); wait_idle();
    scan_read(7'd70, rd); check("scan_70_M", 32'(rd), 32'h4D);
    bus_write(1'b0, 8'h01);
    @(negedge clk);
    rs = 1'b0; rw = 1'b1;
    repeat (2) @(negedge clk);
    e = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_read_oe", 32'(db_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("rst2_oe",     32'(db_oe), 32'd0);
    check("rst2_db_out", 32'(db_out), 32'h00);
    check("rst2_busy",   32'(busy), 32'd1);
    check("rst2_ac",     32'(cursor_addr), 32'h00);
    check("rst2_disp",   32'({display_on, cursor_on, blink_on}), 32'd0);
    check("rst2_perr",   32'(protocol_err), 32'd0);
    e = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    scan_read(7'd70, rd); check("resweep_70", 32'(rd), 32'h20);
    check("rel_busy", 32'(busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
